// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-extension stage: the mode codes
// and the occupancy-state encoding of the output skid buffer.
package imm_pkg;

  localparam logic [1:0] IMM_ZERO   = 2'd0;
  localparam logic [1:0] IMM_SIGN   = 2'd1;
  localparam logic [1:0] IMM_UPPER  = 2'd2;
  localparam logic [1:0] IMM_BRANCH = 2'd3;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extender: (in_data, in_mode) -> (value, neg).
// Zero/sign/upper/branch forms; branch is the sign form shifted left.
module imm_extend_core
  import imm_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic [OUT_W-1:0] value,
  output logic             neg
);

  localparam int EXT_W = OUT_W - IN_W;

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] upper;
  logic [OUT_W-1:0] branch;

  assign zext   = {{EXT_W{1'b0}}, in_data};
  assign sext   = {{EXT_W{in_data[IN_W-1]}}, in_data};
  assign upper  = {in_data, {EXT_W{1'b0}}};
  assign branch = sext << BR_SHIFT;
  assign neg    = in_data[IN_W-1];

  // Select the extended form requested by the mode code
  always_comb begin
    value = zext;
    case (in_mode)
      IMM_ZERO:   value = zext;
      IMM_SIGN:   value = sext;
      IMM_UPPER:  value = upper;
      IMM_BRANCH: value = branch;
      default:    value = zext;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage with a 2-entry skid buffer so that
// in_ready can be a flop while still sustaining one transfer per cycle.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_neg
);

  occ_t             state;
  occ_t             next_state;
  logic [OUT_W-1:0] core_value;
  logic             core_neg;
  logic [OUT_W-1:0] skid_data;
  logic             skid_neg;
  logic             in_xfer;
  logic             out_xfer;
  logic             load_main;
  logic             load_skid;
  logic             skid_to_main;

  imm_extend_core #(
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .BR_SHIFT (BR_SHIFT)
  ) u_core (
    .in_data (in_data),
    .in_mode (in_mode),
    .value   (core_value),
    .neg     (core_neg)
  );

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Occupancy next-state and register-load selection; flush overrides all
  always_comb begin
    next_state   = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      next_state = OCC_EMPTY;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (in_xfer) begin
            next_state = OCC_ONE;
            load_main  = 1'b1;
          end else begin
            next_state = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (in_xfer && out_xfer) begin
            next_state = OCC_ONE;
            load_main  = 1'b1;
          end else if (in_xfer) begin
            next_state = OCC_TWO;
            load_skid  = 1'b1;
          end else if (out_xfer) begin
            next_state = OCC_EMPTY;
          end else begin
            next_state = OCC_ONE;
          end
        end
        OCC_TWO: begin
          if (out_xfer) begin
            next_state   = OCC_ONE;
            skid_to_main = 1'b1;
          end else begin
            next_state = OCC_TWO;
          end
        end
        default: begin
          next_state = OCC_EMPTY;
        end
      endcase
    end
  end

  // State, handshake flags and main/skid data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= OCC_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= {OUT_W{1'b0}};
      out_neg   <= 1'b0;
      skid_data <= {OUT_W{1'b0}};
      skid_neg  <= 1'b0;
    end else begin
      state     <= next_state;
      out_valid <= (next_state != OCC_EMPTY);
      in_ready  <= (next_state != OCC_TWO);
      if (load_main) begin
        out_data <= core_value;
        out_neg  <= core_neg;
      end else if (skid_to_main) begin
        out_data <= skid_data;
        out_neg  <= skid_neg;
      end else begin
        out_data <= out_data;
        out_neg  <= out_neg;
      end
      if (load_skid) begin
        skid_data <= core_value;
        skid_neg  <= core_neg;
      end else begin
        skid_data <= skid_data;
        skid_neg  <= skid_neg;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed mode/handshake/flush/reset
// steps plus randomized traffic on a default and a 12->64 bit instance.
module tb_imm_extend_pipe;

  typedef struct {
    logic [63:0] v;
    logic        n;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [15:0] a_in_data = 16'h0;
  logic [1:0]  a_in_mode = 2'd0;
  logic        a_in_ready, a_out_valid, a_out_neg;
  logic [31:0] a_out_data;

  logic        b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [11:0] b_in_data = 12'h0;
  logic [1:0]  b_in_mode = 2'd0;
  logic        b_in_ready, b_out_valid, b_out_neg;
  logic [63:0] b_out_data;

  int checks = 0;
  int errors = 0;
  int a_pops = 0;
  exp_t a_q[$];
  exp_t b_q[$];

  always #5 clk = ~clk;

  imm_extend_pipe u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_neg(a_out_neg)
  );

  imm_extend_pipe #(.IN_W(12), .OUT_W(64), .BR_SHIFT(1)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_neg(b_out_neg)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: arithmetic view of the extension rules (two's complement value, scaled, wrapped)
  function automatic exp_t ref_ext(input logic [63:0] d, input logic [1:0] m,
                                   input int inw, input int outw, input int sh);
    logic [63:0] mask, s, r;
    exp_t e;
    mask = (outw >= 64) ? {64{1'b1}} : ((64'd1 << outw) - 64'd1);
    s = d;
    if (d[inw-1]) s = d - (64'd1 << inw);
    case (m)
      2'd0:    r = d;
      2'd1:    r = s;
      2'd2:    r = d << (outw - inw);
      default: r = s << sh;
    endcase
    e.v = r & mask;
    e.n = d[inw-1];
    return e;
  endfunction

  // One clock: score transfers seen before the edge, then check hold rules after it
  task automatic tick();
    bit a_in_f, a_out_f, a_hold, a_fl, b_in_f, b_out_f, b_hold;
    logic [31:0] a_prev;
    logic [63:0] b_prev;
    exp_t e;
    a_in_f  = a_in_valid && a_in_ready;
    a_out_f = a_out_valid && a_out_ready;
    a_hold  = a_out_valid && !a_out_ready && !a_flush;
    a_fl    = a_flush;
    a_prev  = a_out_data;
    b_in_f  = b_in_valid && b_in_ready;
    b_out_f = b_out_valid && b_out_ready;
    b_hold  = b_out_valid && !b_out_ready;
    b_prev  = b_out_data;
    if (a_out_f) begin
      check("a_output_expected", 64'(a_q.size() > 0), 64'd1);
      if (a_q.size() > 0) begin
        e = a_q.pop_front();
        check("a_data", 64'(a_out_data), e.v);
        check("a_neg", 64'(a_out_neg), 64'(e.n));
        a_pops++;
      end
    end
    if (a_in_f && !a_fl) a_q.push_back(ref_ext(64'(a_in_data), a_in_mode, 16, 32, 2));
    if (b_out_f) begin
      check("b_output_expected", 64'(b_q.size() > 0), 64'd1);
      if (b_q.size() > 0) begin
        e = b_q.pop_front();
        check("b_data", b_out_data, e.v);
        check("b_neg", 64'(b_out_neg), 64'(e.n));
      end
    end
    if (b_in_f) b_q.push_back(ref_ext(64'(b_in_data), b_in_mode, 12, 64, 1));
    @(posedge clk);
    #1;
    if (a_fl) a_q.delete();
    if (a_hold) begin
      check("a_hold_valid", 64'(a_out_valid), 64'd1);
      check("a_hold_data", 64'(a_out_data), 64'(a_prev));
    end
    if (b_hold) begin
      check("b_hold_valid", 64'(b_out_valid), 64'd1);
      check("b_hold_data", b_out_data, b_prev);
    end
  endtask

  task automatic drain();
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (a_q.size() != 0 || b_q.size() != 0) tick();
    end
    check("a_drain_empty", 64'(a_q.size()), 64'd0);
    check("b_drain_empty", 64'(b_q.size()), 64'd0);
  endtask

  logic [15:0] mv_d[5] = '{16'h8000, 16'h8000, 16'h1234, 16'hFFFF, 16'h7FFF};
  logic [1:0]  mv_m[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
  logic [31:0] mv_e[5] = '{32'h00008000, 32'hFFFF8000, 32'h12340000, 32'hFFFFFFFC, 32'h00007FFF};
  logic        mv_n[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    int p0;
    bit all_ready;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_out_data", 64'(a_out_data), 64'd0);
    check("rst_out_neg", 64'(a_out_neg), 64'd0);

    // Mode vectors, one per cycle, each visible one cycle after its transfer
    a_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1'b1; a_in_data = mv_d[i]; a_in_mode = mv_m[i];
      tick();
      check("mode_valid", 64'(a_out_valid), 64'd1);
      check("mode_data", 64'(a_out_data), 64'(mv_e[i]));
      check("mode_neg", 64'(a_out_neg), 64'(mv_n[i]));
    end
    a_in_valid = 1'b0;
    tick();
    check("mode_idle_valid", 64'(a_out_valid), 64'd0);

    // Backpressure: two accepted then stall, then release in order
    p0 = a_pops;
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_mode = 2'd1; a_in_data = 16'h0001;
    tick();
    check("bp_ready_one", 64'(a_in_ready), 64'd1);
    check("bp_data_one", 64'(a_out_data), 64'h1);
    a_in_data = 16'h0002;
    tick();
    check("bp_ready_two", 64'(a_in_ready), 64'd0);
    check("bp_data_two", 64'(a_out_data), 64'h1);
    a_in_data = 16'h0003;
    tick();
    check("bp_ready_stall", 64'(a_in_ready), 64'd0);
    check("bp_data_stall", 64'(a_out_data), 64'h1);
    a_out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (a_in_valid && a_in_ready && a_in_data == 16'h0003) begin
        tick();
        a_in_data = 16'h0004;
      end else if (a_in_valid && a_in_ready && a_in_data == 16'h0004) begin
        tick();
        a_in_valid = 1'b0;
      end else begin
        tick();
      end
    end
    check("bp_pop_count", 64'(a_pops - p0), 64'd4);
    drain();

    // Full throughput: eight back-to-back transfers
    p0 = a_pops;
    all_ready = 1'b1;
    a_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_in_valid = 1'b1; a_in_data = 16'($urandom); a_in_mode = 2'($urandom_range(0, 3));
      if (!a_in_ready) all_ready = 1'b0;
      tick();
      check("tp_out_valid", 64'(a_out_valid), 64'd1);
    end
    a_in_valid = 1'b0;
    tick();
    check("tp_in_ready_const", 64'(all_ready), 64'd1);
    check("tp_pop_count", 64'(a_pops - p0), 64'd8);

    // Flush with both entries held and a concurrent input
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_mode = 2'd1;
    a_in_data = 16'h0011; tick();
    a_in_data = 16'h0022; tick();
    check("fl_full", 64'(a_in_ready), 64'd0);
    a_flush = 1'b1; a_in_data = 16'h0033;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    check("fl_out_valid", 64'(a_out_valid), 64'd0);
    check("fl_in_ready", 64'(a_in_ready), 64'd1);
    a_out_ready = 1'b1;
    repeat (3) tick();
    check("fl_nothing_after", 64'(a_out_valid), 64'd0);

    // Asynchronous reset mid-cycle with two entries held
    a_out_ready = 1'b0; a_in_valid = 1'b1;
    a_in_data = 16'h0044; tick();
    a_in_data = 16'h0055; tick();
    a_in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", 64'(a_out_valid), 64'd0);
    check("ar_out_data", 64'(a_out_data), 64'd0);
    check("ar_in_ready", 64'(a_in_ready), 64'd1);
    a_q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    a_out_ready = 1'b1;
    repeat (3) tick();
    check("ar_nothing_after", 64'(a_out_valid), 64'd0);

    // Wide instance boundary case
    b_out_ready = 1'b1; b_in_valid = 1'b1; b_in_data = 12'h800; b_in_mode = 2'd3;
    tick();
    check("b_branch_data", b_out_data, 64'hFFFFFFFFFFFFF000);
    check("b_branch_neg", 64'(b_out_neg), 64'd1);
    b_in_valid = 1'b0;
    tick();

    // Random traffic on both instances
    for (int i = 0; i < 400; i++) begin
      a_in_valid = 1'($urandom_range(0, 1)); a_in_data = 16'($urandom);
      a_in_mode = 2'($urandom_range(0, 3)); a_out_ready = ($urandom_range(0, 3) != 0);
      b_in_valid = 1'($urandom_range(0, 1)); b_in_data = 12'($urandom);
      b_in_mode = 2'($urandom_range(0, 3)); b_out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
